// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode and datapath select encodings for the multicycle MIPS control
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_DECODE     = 5'd3,
    S_R_EXEC     = 5'd4,
    S_R_WB       = 5'd5,
    S_MEM_ADDR   = 5'd6,
    S_MEM_READ   = 5'd7,
    S_MEM_WAIT   = 5'd8,
    S_MEM_WB     = 5'd9,
    S_MEM_WRITE  = 5'd10,
    S_BEQ        = 5'd11,
    S_JUMP       = 5'd12,
    S_ADDI_EXEC  = 5'd13,
    S_ADDI_WB    = 5'd14,
    S_EXC        = 5'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_MDR  = 2'b01;
  localparam logic [1:0] SRCA_REGA = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       epc_write;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control-to-datapath signal bundle; master is the FSM, slave the datapath
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 5
);
  logic [5:0]         Opcode;
  logic               Zero;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MDRWrite;
  logic               ABWrite;
  logic               ALUOutWrite;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ALUOp;
  logic [1:0]         PCSource;
  logic               EPCWrite;
  logic [STATE_W-1:0] StateOut;

  modport master (
    input  Opcode, Zero,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MDRWrite, ABWrite,
           ALUOutWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           EPCWrite, StateOut
  );

  modport slave (
    output Opcode, Zero,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MDRWrite, ABWrite,
           ALUOutWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           EPCWrite, StateOut
  );
endinterface

// File: rtl/multicycle_control_fsm_control_output_decoder.sv
// rtl/multicycle_control_fsm_control_output_decoder.sv - Moore state -> control vector table (S_EXC row under UNKNOWN_OPCODE_EXC_EN)
module control_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ior_d    = 1'b0;
        ctrl.mem_read = 1'b1;
      end
      S_FETCH_WAIT: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Branch target is precomputed here so S_BEQ only needs the compare.
        ctrl.ab_write      = 1'b1;
        ctrl.alu_src_a     = SRCA_PC;
        ctrl.alu_src_b     = SRCB_IMM_SH2;
        ctrl.alu_op        = ALUOP_ADD;
        ctrl.alu_out_write = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_FUNCT;
        ctrl.alu_out_write = 1'b1;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_IMM;
        ctrl.alu_op        = ALUOP_ADD;
        ctrl.alu_out_write = 1'b1;
      end
      S_MEM_READ: begin
        ctrl.ior_d    = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WAIT: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.mdr_write = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`ifdef UNKNOWN_OPCODE_EXC_EN
      S_EXC: begin
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.epc_write = 1'b1;
        ctrl.pc_source = PCSRC_EXC;
        ctrl.pc_write  = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control FSM; UNKNOWN_OPCODE_EXC_EN enables the S_EXC trap path
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int          STATE_W    = 5,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  ctrl_if
);

  state_t state;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:      state <= S_FETCH;
        S_FETCH:      state <= S_FETCH_WAIT;
        S_FETCH_WAIT: state <= S_DECODE;
        S_DECODE: begin
          case (ctrl_if.Opcode)
            OP_RTYPE:     state <= S_R_EXEC;
            OP_LW, OP_SW: state <= S_MEM_ADDR;
            OP_BEQ:       state <= S_BEQ;
            OP_J:         state <= S_JUMP;
            OP_ADDI:      state <= S_ADDI_EXEC;
`ifdef UNKNOWN_OPCODE_EXC_EN
            default:      state <= S_EXC;
`else
            default:      state <= S_FETCH;
`endif
          endcase
        end
        S_R_EXEC:    state <= S_R_WB;
        S_MEM_ADDR:  state <= (ctrl_if.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  state <= S_MEM_WAIT;
        S_MEM_WAIT:  state <= S_MEM_WB;
        S_ADDI_EXEC: state <= S_ADDI_WB;
        S_R_WB, S_MEM_WB, S_MEM_WRITE, S_BEQ, S_JUMP, S_ADDI_WB:
                     state <= S_FETCH;
`ifdef UNKNOWN_OPCODE_EXC_EN
        S_EXC:       state <= S_FETCH;
`endif
        default:     state <= S_RESET;
      endcase
    end
  end

  control_output_decoder u_decoder (
    .state (state),
    .ctrl  (ctrl)
  );

  assign ctrl_if.PCWrite     = ctrl.pc_write;
  assign ctrl_if.PCWriteCond = ctrl.pc_write_cond;
  assign ctrl_if.IorD        = ctrl.ior_d;
  assign ctrl_if.MemRead     = ctrl.mem_read;
  assign ctrl_if.MemWrite    = ctrl.mem_write;
  assign ctrl_if.IRWrite     = ctrl.ir_write;
  assign ctrl_if.MDRWrite    = ctrl.mdr_write;
  assign ctrl_if.ABWrite     = ctrl.ab_write;
  assign ctrl_if.ALUOutWrite = ctrl.alu_out_write;
  assign ctrl_if.RegWrite    = ctrl.reg_write;
  assign ctrl_if.RegDst      = ctrl.reg_dst;
  assign ctrl_if.MemtoReg    = ctrl.mem_to_reg;
  assign ctrl_if.ALUSrcA     = ctrl.alu_src_a;
  assign ctrl_if.ALUSrcB     = ctrl.alu_src_b;
  assign ctrl_if.ALUOp       = ctrl.alu_op;
  assign ctrl_if.PCSource    = ctrl.pc_source;
  assign ctrl_if.EPCWrite    = ctrl.epc_write;
  assign ctrl_if.StateOut    = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized instruction-stream bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.STATE_W(5)) dut_if ();

  multicycle_control_fsm #(
    .STATE_W    (5),
    .EXC_VECTOR (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_if (dut_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  string phases[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] observed();
    return 32'({dut_if.PCWrite, dut_if.PCWriteCond, dut_if.IorD, dut_if.MemRead,
                dut_if.MemWrite, dut_if.IRWrite, dut_if.MDRWrite, dut_if.ABWrite,
                dut_if.ALUOutWrite, dut_if.RegWrite, dut_if.RegDst, dut_if.MemtoReg,
                dut_if.ALUSrcA, dut_if.ALUSrcB, dut_if.ALUOp, dut_if.PCSource,
                dut_if.EPCWrite});
  endfunction

  // Expected control lines per step, listed straight from the instruction walkthrough.
  function automatic logic [31:0] exp_ctrl(input string ph);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, mdrw = 0;
    logic abw = 0, aow = 0, rw = 0, rd = 0, m2r = 0, epc = 0;
    logic [1:0] sa = 0, sb = 0, op = 0, ps = 0;
    case (ph)
      "FETCH":      mr = 1;
      "FETCH_WAIT": begin mr = 1; irw = 1; sb = 2'b01; pcw = 1; end
      "DECODE":     begin abw = 1; sb = 2'b11; aow = 1; end
      "R_EXEC":     begin sa = 2'b10; op = 2'b10; aow = 1; end
      "R_WB":       begin rd = 1; rw = 1; end
      "MEM_ADDR":   begin sa = 2'b10; sb = 2'b10; aow = 1; end
      "MEM_READ":   begin iord = 1; mr = 1; end
      "MEM_WAIT":   begin iord = 1; mr = 1; mdrw = 1; end
      "MEM_WB":     begin m2r = 1; rw = 1; end
      "MEM_WRITE":  begin iord = 1; mw = 1; end
      "BEQ":        begin sa = 2'b10; op = 2'b01; ps = 2'b01; pcwc = 1; end
      "JUMP":       begin ps = 2'b10; pcw = 1; end
      "ADDI_EXEC":  begin sa = 2'b10; sb = 2'b10; aow = 1; end
      "ADDI_WB":    rw = 1;
      "EXC":        begin sb = 2'b01; op = 2'b01; epc = 1; ps = 2'b11; pcw = 1; end
      default:      ;
    endcase
    return 32'({pcw, pcwc, iord, mr, mw, irw, mdrw, abw, aow, rw, rd, m2r, sa, sb, op, ps, epc});
  endfunction

  function automatic logic [31:0] exp_state(input string ph);
    case (ph)
      "FETCH":      return 32'(S_FETCH);
      "FETCH_WAIT": return 32'(S_FETCH_WAIT);
      "DECODE":     return 32'(S_DECODE);
      "R_EXEC":     return 32'(S_R_EXEC);
      "R_WB":       return 32'(S_R_WB);
      "MEM_ADDR":   return 32'(S_MEM_ADDR);
      "MEM_READ":   return 32'(S_MEM_READ);
      "MEM_WAIT":   return 32'(S_MEM_WAIT);
      "MEM_WB":     return 32'(S_MEM_WB);
      "MEM_WRITE":  return 32'(S_MEM_WRITE);
      "BEQ":        return 32'(S_BEQ);
      "JUMP":       return 32'(S_JUMP);
      "ADDI_EXEC":  return 32'(S_ADDI_EXEC);
      "ADDI_WB":    return 32'(S_ADDI_WB);
      "EXC":        return 32'(S_EXC);
      default:      return 32'(S_RESET);
    endcase
  endfunction

  task automatic build_phases(input logic [5:0] op);
    phases = '{"FETCH", "FETCH_WAIT", "DECODE"};
    case (op)
      6'h00: begin phases.push_back("R_EXEC"); phases.push_back("R_WB"); end
      6'h23: begin
        phases.push_back("MEM_ADDR"); phases.push_back("MEM_READ");
        phases.push_back("MEM_WAIT"); phases.push_back("MEM_WB");
      end
      6'h2B: begin phases.push_back("MEM_ADDR"); phases.push_back("MEM_WRITE"); end
      6'h04: phases.push_back("BEQ");
      6'h02: phases.push_back("JUMP");
      6'h08: begin phases.push_back("ADDI_EXEC"); phases.push_back("ADDI_WB"); end
`ifdef UNKNOWN_OPCODE_EXC_EN
      default: phases.push_back("EXC");
`else
      default: ;
`endif
    endcase
  endtask

  // Enters at a negedge with the DUT in FETCH; leaves at the negedge of the next FETCH
  // unless abort_at names a step, in which case it stops after checking that step.
  task automatic run_instr(input logic [5:0] op, input int idx, input int zero_mode, input int abort_at);
    dut_if.Opcode = op;
    build_phases(op);
    for (int k = 0; k < phases.size(); k++) begin
      dut_if.Zero = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
      #1;
      check($sformatf("i%0d op%02h %s state", idx, op, phases[k]), 32'(dut_if.StateOut), exp_state(phases[k]));
      check($sformatf("i%0d op%02h %s ctrl", idx, op, phases[k]), observed(), exp_ctrl(phases[k]));
      check($sformatf("i%0d rd_wr_excl", idx), 32'(dut_if.MemRead & dut_if.MemWrite), 32'd0);
      check($sformatf("i%0d regw_pcw_excl", idx), 32'(dut_if.RegWrite & dut_if.PCWrite), 32'd0);
      if (k == abort_at) return;
      @(negedge clk);
    end
  endtask

  logic [5:0] directed[8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h04, 6'h02, 6'h08, 6'h3F};
  logic [5:0] known[6]    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
  logic [5:0] unknown[5]  = '{6'h3F, 6'h01, 6'h10, 6'h2A, 6'h05};

  initial begin
    reset = 1'b1;
    dut_if.Opcode = 6'h00;
    dut_if.Zero   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset state", 32'(dut_if.StateOut), 32'(S_RESET));
    check("reset ctrl", observed(), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_instr(directed[i], i, (i == 3) ? 0 : (i == 4) ? 1 : 2, -1);
    end

    // Reset lands in the middle of a load, while the data is being captured.
    run_instr(6'h23, 100, 2, 5);
    #2 reset = 1'b1;
    #1;
    check("midreset state", 32'(dut_if.StateOut), 32'(S_RESET));
    check("midreset ctrl", observed(), 32'd0);
    @(negedge clk);
    check("held reset ctrl", observed(), 32'd0);
    reset = 1'b0;
    #1 check("released state", 32'(dut_if.StateOut), 32'(S_RESET));
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 5) == 0) op = unknown[$urandom_range(0, 4)];
      else                           op = known[$urandom_range(0, 5)];
      run_instr(op, 200 + i, 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
